// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, PP_PER_CYCLE digits per cycle, full 2*WIDTH product, valid/ready both sides.
// Latency ceil(NDIG/PP_PER_CYCLE) edges after accept; holds result in DONE until out_ready. `define BOOTH_EARLY_TERM_EN for early exit.
module booth_mul_seq #(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_a_signed,
    input  logic                 in_b_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int NDIG = (WIDTH + 2) / 2;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int KW   = $clog2(NDIG + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] a_q, a_d;
    logic [EW-1:0] b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;

    logic [AW-1:0] acc_sum;
    logic [KW-1:0] k_next;
    logic [EW:0]   b_pad;
    logic          last_step;

    // Multiplier with the implicit bit -1 = 0 appended at the bottom.
    assign b_pad = {b_q, 1'b0};

    function automatic logic [2:0] get_digit(input logic [EW:0] bp, input int d);
        logic [EW:0] sh;
        sh = bp >> (2 * d);
        return sh[2:0];
    endfunction

    function automatic logic [AW-1:0] pp_term(input logic [2:0] trip, input logic [EW-1:0] a,
                                              input int d);
        logic          set0, x2, inv;
        logic [AW-1:0] m;
        set0 = (trip == 3'b000) || (trip == 3'b111);
        x2   = (trip == 3'b011) || (trip == 3'b100);
        inv  = trip[2] & ~(trip[1] & trip[0]);
        m    = {{(AW-EW){a[EW-1]}}, a};
        if (x2)   m = m << 1;
        if (set0) m = '0;
        if (inv)  m = ~m;
        return (m << (2 * d)) + (AW'(inv) << (2 * d));
    endfunction

    always_comb begin
        acc_sum = acc_q;
        k_next  = k_q;
        for (int j = 0; j < PP_PER_CYCLE; j++) begin
            if (int'(k_q) + j < NDIG) begin
                acc_sum = acc_sum + pp_term(get_digit(b_pad, int'(k_q) + j), a_q, int'(k_q) + j);
                k_next  = k_next + KW'(1);
            end
        end
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [EW:0] sign_run;
    logic        et_hit;

    // Remaining digits are all zero when the untouched multiplier bits are a pure sign run.
    always_comb begin
        sign_run = {(EW+1){b_q[EW-1]}} >> (2 * int'(k_next));
        et_hit   = ((b_pad >> (2 * int'(k_next))) == sign_run);
    end

    assign last_step = (int'(k_next) >= NDIG) || et_hit;
`else
    assign last_step = (int'(k_next) >= NDIG);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    state_d = S_BUSY;
                    a_d     = {{2{in_a_signed & in_a[WIDTH-1]}}, in_a};
                    b_d     = {{2{in_b_signed & in_b[WIDTH-1]}}, in_b};
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_next;
                    if (last_step) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out_product = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: two instances (1 and 2 digits/cycle) share stimulus; products and latency come from an arithmetic model.
module tb_booth_mul_seq;

    localparam int W    = 32;
    localparam int NDIG = (W + 2) / 2;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [W-1:0]  in_a, in_b;
    logic          in_a_signed, in_b_signed;
    logic          in_ready1, out_valid1, busy1;
    logic          in_ready2, out_valid2, busy2;
    logic [2*W-1:0] prod1, prod2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W), .PP_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
        .out_valid(out_valid1), .out_ready(out_ready), .out_product(prod1), .busy(busy1)
    );

    booth_mul_seq #(.WIDTH(W), .PP_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
        .out_valid(out_valid2), .out_ready(out_ready), .out_product(prod2), .busy(busy2)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic as, input logic bs);
        logic signed [W+1:0]   ea, eb;
        logic signed [2*W+3:0] p;
        ea = as ? {{2{a[W-1]}}, a} : {2'b00, a};
        eb = bs ? {{2{b[W-1]}}, b} : {2'b00, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input logic bs, input int ppc);
        int full;
        full = (NDIG + ppc - 1) / ppc;
`ifdef BOOTH_EARLY_TERM_EN
        begin
            logic signed [W+1:0] eb, t;
            int kk;
            eb = bs ? {{2{b[W-1]}}, b} : {2'b00, b};
            for (int c = 1; c <= full; c++) begin
                kk = (c * ppc < NDIG) ? c * ppc : NDIG;
                t  = eb >>> (2 * kk - 1);
                if (t == '0 || t == '1) return c;
            end
        end
`endif
        return full;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic as, input logic bs);
        in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
        in_a_signed = 1'($urandom_range(0, 1));
        in_b_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic as,
                          input logic bs, input int hold);
        int lat1, lat2;
        logic [2*W-1:0] exp, snap;
        lat1 = 0; lat2 = 0;
        exp  = ref_mul(a, b, as, bs);
        accept(a, b, as, bs);
        chk("in_ready_after_accept", 64'(in_ready1), 64'd0);
        for (int n = 1; n <= 40 && (lat1 == 0 || lat2 == 0); n++) begin
            tick();
            if (lat1 == 0 && out_valid1) lat1 = n;
            if (lat2 == 0 && out_valid2) lat2 = n;
        end
        chk("latency_ppc1", 64'(lat1), 64'(ref_lat(b, bs, 1)));
        chk("latency_ppc2", 64'(lat2), 64'(ref_lat(b, bs, 2)));
        chk("product_ppc1", prod1, exp);
        chk("product_ppc2", prod2, exp);
        snap = prod1;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 64'(out_valid1), 64'd1);
            chk("hold_product", prod1, snap);
            chk("hold_in_ready", 64'(in_ready1), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_handshake_in_ready", 64'(in_ready1 & in_ready2), 64'd1);
        chk("post_handshake_valid", 64'(out_valid1 | out_valid2), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready1 & in_ready2), 64'd1);
        chk("rst_out_valid", 64'(out_valid1 | out_valid2), 64'd0);
        chk("rst_busy", 64'(busy1 | busy2), 64'd0);
        chk("rst_product1", prod1, 64'd0);
        chk("rst_product2", prod2, 64'd0);
        rst = 1'b0;
        tick();

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
        run_op(32'd7, 32'd3, 1'b0, 1'b0, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 5);

        // Flush on the fifth BUSY cycle.
        accept(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("busy_before_flush", 64'(busy1 & busy2), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy1 | busy2), 64'd0);
        chk("flush_in_ready", 64'(in_ready1 & in_ready2), 64'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("flush_no_valid", 64'(out_valid1 | out_valid2), 64'd0);
        end
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 0);

        // Flush in IDLE beats a simultaneous request.
        flush = 1'b1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("idle_flush_no_accept", 64'(busy1 | busy2), 64'd0);

        // Reset mid-operation.
        accept(32'hCAFE_0001, 32'h7777_7777, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready1 & in_ready2), 64'd1);
        chk("midrst_out_valid", 64'(out_valid1 | out_valid2), 64'd0);
        chk("midrst_busy", 64'(busy1 | busy2), 64'd0);
        chk("midrst_product1", prod1, 64'd0);
        chk("midrst_product2", prod2, 64'd0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case (i % 4)
                1: rb = W'($urandom_range(0, 255));
                2: rb = ~W'($urandom_range(0, 255));
                3: ra = W'($urandom_range(0, 15));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Parametrised, iterative radix-4 Booth multiplier for the core's MUL/MULH/MULHSU/MULHU path. Generalises the fixed 17-row combinational partial-product generator: operand width is a parameter, per-operand signedness is selectable, and PP_PER_CYCLE Booth digits are recoded and accumulated each cycle. The block sits between the issue stage (valid/ready in) and writeback (valid/ready out) and returns the full 2*WIDTH-bit product.

Parameters:
WIDTH, 32, operand width; even, >= 4
PP_PER_CYCLE, 1, Booth digits accumulated per BUSY cycle; 1..NDIG, where NDIG = (WIDTH+2)/2

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  kill in-flight operation
in_valid  input  1  operand request
in_ready  output  1  block can accept; high only in IDLE
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier (recoded)
in_a_signed  input  1  1 = in_a two's complement
in_b_signed  input  1  1 = in_b two's complement
out_valid  output  1  product available
out_ready  input  1  consumer accepts product
out_product  output  2*WIDTH  full product
busy  output  1  state != IDLE

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. Reset has priority over every other input.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_product = 0, accumulator = 0, digit counter = 0.
- States:
  - IDLE -> BUSY on in_valid && in_ready.
  - BUSY -> DONE on the edge that processes the last digit.
  - DONE -> IDLE on out_valid && out_ready.
- Accept edge:
  - Extend each operand to WIDTH+2 bits: sign-extend if its signed flag is set, else zero-extend.
  - Latch the extended operands, clear the accumulator and the digit counter k.
- Digit k is formed from multiplier bits (2k+1, 2k, 2k-1); bit -1 = 0. Decode to {0, ±1, ±2} × multiplicand:
  - set0: digit is zero.
  - x2: shift left 1.
  - inv: one's complement, plus an inv-bit correction at weight 2^(2k).
- Each BUSY edge adds min(PP_PER_CYCLE, NDIG-k) digits. Each digit is sign-extended to the accumulator width and shifted by 2k. k advances by the same amount.
- Accumulator width is 2*WIDTH+4. out_product = accumulator[2*WIDTH-1:0], which is exact for all four signedness modes.
- Latency: out_valid rises ceil(NDIG/PP_PER_CYCLE) edges after the accept edge. For WIDTH=32: 17 edges at PP_PER_CYCLE=1, 9 edges at PP_PER_CYCLE=2.
- DONE: out_valid = 1. out_product is held stable until the output handshake; in_ready = 0. No new operation is accepted in the handshake cycle; in_ready rises the edge after.
- flush (no rst): from BUSY or DONE, go to IDLE at the next edge. out_valid deasserts and the result is discarded. In IDLE, flush is ignored; if in_valid is high in the same cycle, flush wins and nothing is accepted.
- in_a/in_b changes while BUSY have no effect; operands are latched.

Optional Feature:
BOOTH_EARLY_TERM_EN
- Defined: in BUSY, after processing digits up to k-1, if multiplier bits [WIDTH+1 : 2k-1] are all equal, every remaining digit is zero. The FSM goes to DONE that edge. Minimum latency is 1 edge. The result is identical to the full run.
- Undefined: latency is always ceil(NDIG/PP_PER_CYCLE). No comparison logic is instantiated.

Test Plan:
1. WIDTH=32, PPC=1, a=b=0xFFFFFFFF, both signed -> out_product=0x0000000000000001; out_valid exactly 17 edges after accept.
2. a=b=0xFFFFFFFF, both unsigned -> 0xFFFFFFFE00000001. PPC=2 variant: same value, out_valid after 9 edges.
3. a=0x80000000 signed, b=0x7FFFFFFF unsigned -> 0xC000000080000000.
4. Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_product stable, in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
5. Assert flush on the 5th BUSY cycle -> IDLE next edge, no out_valid. Next op a=3, b=5, unsigned -> 15. Also: rst mid-BUSY -> all reset values next edge.
6. With BOOTH_EARLY_TERM_EN, a=7, b=3, unsigned -> 21, out_valid 2 edges after accept. Without the macro: 21 after 17 edges.
